// File: rtl/fp_divsqrt_pkg.sv
// fp_divsqrt_pkg: shared widths, flag indices and the response record for the div/sqrt result path.
// Revision: 1.0
`default_nettype none

package fp_divsqrt_pkg;

  localparam int FLEN   = 65;
  localparam int FLAG_W = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int ERR_ORPHAN   = 0;
  localparam int ERR_OVERFLOW = 1;

  // The tag field is sized for the widest tag any instance may use; instances zero-extend.
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [FLEN-1:0]      data;
    logic [FLAG_W-1:0]    flags;
    logic [TAG_W_MAX-1:0] tag;
    logic                 is_sqrt;
  } divsqrt_resp_t;

endpackage

`default_nettype wire

// File: rtl/divsqrt_resp_buffer_sync_fifo.sv
// sync_fifo: parametric synchronous FIFO, any DEPTH >= 1, head forced to zero when empty.
// Revision: 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still honoured.
  assign do_push = push && (!full || do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/divsqrt_resp_buffer.sv
// divsqrt_resp_buffer: tags div/sqrt result pulses, buffers them for writeback, issues credit.
// Revision: 1.0
`default_nettype none

module divsqrt_resp_buffer
  import fp_divsqrt_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  output logic              issue_allow,
  input  logic              issue_fire,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              res_valid_div,
  input  logic              res_valid_sqrt,
  input  logic [FLEN-1:0]   res_data,
  input  logic [FLAG_W-1:0] res_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLEN-1:0]   out_data,
  output logic [FLAG_W-1:0] out_flags,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_is_sqrt,
  output logic [1:0]        err_sticky
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int RESP_W = $bits(divsqrt_resp_t);

  logic              inflight;
  logic [TAG_W-1:0]  tag_q;
  logic [1:0]        err_q;

  logic              any_pulse;
  logic              result_ok;
  logic              pop;
  logic              overflow;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  divsqrt_resp_t     push_resp;
  divsqrt_resp_t     head_resp;
  logic [RESP_W-1:0] head_bits;
  logic              unused_tag_hi;

  assign any_pulse = res_valid_div | res_valid_sqrt;
  assign result_ok = (res_valid_div ^ res_valid_sqrt) & inflight;
  assign pop       = out_valid & out_ready;
  assign overflow  = result_ok & fifo_full & ~pop;

  always_comb begin
    push_resp         = '0;
    push_resp.data    = res_data;
    push_resp.flags   = res_flags;
    push_resp.tag     = TAG_W_MAX'(tag_q);
    push_resp.is_sqrt = res_valid_sqrt;
  end

  sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (result_ok),
    .push_data (push_resp),
    .pop       (pop),
    .head_data (head_bits),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign head_resp   = divsqrt_resp_t'(head_bits);
  assign out_valid   = ~fifo_empty;
  assign out_data    = head_resp.data;
  assign out_flags   = head_resp.flags;
  assign out_tag     = head_resp.tag[TAG_W-1:0];
  assign out_is_sqrt = head_resp.is_sqrt;
  assign unused_tag_hi = ^head_resp.tag;

  // Credit reserves a slot for the op still in the unit; registered state only.
  assign issue_allow = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(DEPTH);

  assign err_sticky = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      tag_q    <= '0;
      err_q    <= 2'b00;
    end else begin
      if (issue_fire) begin
        inflight <= 1'b1;
        tag_q    <= issue_tag;
      end else if (result_ok) begin
        inflight <= 1'b0;
      end
      if (any_pulse && !result_ok) begin
        err_q[ERR_ORPHAN] <= 1'b1;
      end
      if (overflow) begin
        err_q[ERR_OVERFLOW] <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
